// File: rtl/display_defs.sv
// Shared constants for the count display path: segment patterns,
// conversion FSM encoding and one-hot digit enables.
package display_defs;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_SHIFT = 2'd1,
    ST_DONE  = 2'd2
  } state_e;

  // Segment patterns, bit order {g,f,e,d,c,b,a}, active-high
  localparam logic [6:0] SEG_0     = 7'h3F;
  localparam logic [6:0] SEG_1     = 7'h06;
  localparam logic [6:0] SEG_2     = 7'h5B;
  localparam logic [6:0] SEG_3     = 7'h4F;
  localparam logic [6:0] SEG_4     = 7'h66;
  localparam logic [6:0] SEG_5     = 7'h6D;
  localparam logic [6:0] SEG_6     = 7'h7D;
  localparam logic [6:0] SEG_7     = 7'h07;
  localparam logic [6:0] SEG_8     = 7'h7F;
  localparam logic [6:0] SEG_9     = 7'h6F;
  localparam logic [6:0] SEG_BLANK = 7'h00;

  // Digit enables, active-high one-hot
  localparam logic [2:0] DIGIT_ONES     = 3'b001;
  localparam logic [2:0] DIGIT_TENS     = 3'b010;
  localparam logic [2:0] DIGIT_HUNDREDS = 3'b100;

  // BCD nibble to segment pattern; non-decimal nibbles go dark
  function automatic logic [6:0] seg_decode(input logic [3:0] nib);
    logic [6:0] s;
    case (nib)
      4'd0:    s = SEG_0;
      4'd1:    s = SEG_1;
      4'd2:    s = SEG_2;
      4'd3:    s = SEG_3;
      4'd4:    s = SEG_4;
      4'd5:    s = SEG_5;
      4'd6:    s = SEG_6;
      4'd7:    s = SEG_7;
      4'd8:    s = SEG_8;
      4'd9:    s = SEG_9;
      default: s = SEG_BLANK;
    endcase
    return s;
  endfunction

endpackage

// File: rtl/bin2bcd_seq.sv
// Sequential double-dabble converter: 8-bit binary to 3 BCD digits.
// A new conversion starts only from IDLE when the input differs from the
// last value converted; input changes mid-conversion are picked up later.
module bin2bcd_seq
  import display_defs::*;
(
  input  logic        clk,
  input  logic        rst_n,
  input  logic [7:0]  count_in,
  output logic [11:0] bcd_out,
  output logic        bcd_valid,
  output logic        busy
);

  state_e      state_q, state_d;
  logic [19:0] shift_q, shift_d;
  logic [7:0]  last_q, last_d;
  logic [2:0]  iter_q, iter_d;
  logic [11:0] bcd_q, bcd_d;
  logic        valid_q, valid_d;
  logic [19:0] adjusted;

  // Add-3 correction on each BCD nibble before it is shifted
  always_comb begin
    adjusted = shift_q;
    for (int i = 0; i < 3; i++) begin
      if (shift_q[8+4*i +: 4] >= 4'd5)
        adjusted[8+4*i +: 4] = shift_q[8+4*i +: 4] + 4'd3;
    end
  end

  // Next-state and datapath control
  always_comb begin
    state_d = state_q;
    shift_d = shift_q;
    last_d  = last_q;
    iter_d  = iter_q;
    bcd_d   = bcd_q;
    valid_d = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (count_in != last_q) begin
          shift_d = {12'h000, count_in};
          last_d  = count_in;
          iter_d  = 3'd0;
          state_d = ST_SHIFT;
        end
      end
      ST_SHIFT: begin
        shift_d = {adjusted[18:0], 1'b0};
        iter_d  = iter_q + 3'd1;
        if (iter_q == 3'd7)
          state_d = ST_DONE;
      end
      ST_DONE: begin
        bcd_d   = shift_q[19:8];
        valid_d = 1'b1;
        state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // State registers; reset aborts any conversion immediately
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= ST_IDLE;
      shift_q <= '0;
      last_q  <= '0;
      iter_q  <= '0;
      bcd_q   <= '0;
      valid_q <= 1'b0;
    end else begin
      state_q <= state_d;
      shift_q <= shift_d;
      last_q  <= last_d;
      iter_q  <= iter_d;
      bcd_q   <= bcd_d;
      valid_q <= valid_d;
    end
  end

  assign bcd_out   = bcd_q;
  assign bcd_valid = valid_q;
  assign busy      = (state_q != ST_IDLE);

endmodule

// File: rtl/count_display_driver.sv
// Converts the counter value to BCD and scans it onto a 3-digit
// multiplexed 7-segment display, with optional leading-zero blanking.
module count_display_driver
  import display_defs::*;
#(
  parameter int unsigned REFRESH_DIV   = 1000,
  parameter bit          BLANK_LEADING = 1'b1
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [7:0]  count_in,
  output logic [11:0] bcd_out,
  output logic        bcd_valid,
  output logic        busy,
  output logic [2:0]  an,
  output logic [6:0]  seg
);

  localparam logic [15:0] REFRESH_LAST = 16'(REFRESH_DIV - 1);

  logic [15:0] refresh_q, refresh_d;
  logic [1:0]  digit_q, digit_d;
  logic [3:0]  nib;
  logic        blank;

  bin2bcd_seq u_bin2bcd (
    .clk       (clk),
    .rst_n     (reset),
    .count_in  (count_in),
    .bcd_out   (bcd_out),
    .bcd_valid (bcd_valid),
    .busy      (busy)
  );

  // Refresh divider: digit index advances on the terminal count
  always_comb begin
    refresh_d = refresh_q + 16'd1;
    digit_d   = digit_q;
    if (refresh_q == REFRESH_LAST) begin
      refresh_d = 16'd0;
      digit_d   = (digit_q == 2'd2) ? 2'd0 : digit_q + 2'd1;
    end
  end

  // Refresh counter and digit index registers
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      refresh_q <= '0;
      digit_q   <= '0;
    end else begin
      refresh_q <= refresh_d;
      digit_q   <= digit_d;
    end
  end

  // Digit mux and blanking; follows bcd_out with no extra register stage
  always_comb begin
    an    = DIGIT_ONES;
    nib   = bcd_out[3:0];
    blank = 1'b0;
    case (digit_q)
      2'd1: begin
        an    = DIGIT_TENS;
        nib   = bcd_out[7:4];
        blank = BLANK_LEADING && (bcd_out[11:8] == 4'd0) && (bcd_out[7:4] == 4'd0);
      end
      2'd2: begin
        an    = DIGIT_HUNDREDS;
        nib   = bcd_out[11:8];
        blank = BLANK_LEADING && (bcd_out[11:8] == 4'd0);
      end
      default: ;
    endcase
    seg = blank ? SEG_BLANK : seg_decode(nib);
  end

endmodule
